// File: rtl/level_gen.sv
// Tick-to-level pulse generator: turns an accepted single-cycle tick into a
// programmable-length high pulse followed by a guaranteed low gap.
module level_gen #(
  parameter int WIDTH_W = 8,
  parameter int GAP     = 2,
  parameter int RETRIG  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [WIDTH_W-1:0] width,
  output logic               level,
  output logic               busy,
  output logic               overrun
);

  localparam int GAP_BITS = $clog2(GAP + 1);
  localparam int CW       = (WIDTH_W > GAP_BITS) ? WIDTH_W : GAP_BITS;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_GAP = CW'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [WIDTH_W-1:0]   pend_w_q, pend_w_d;
  logic                 drop;
  logic                 req;
  logic                 last;

  assign req  = tick && (width != '0);
  assign last = (cnt_q == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      pend_w_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_w_q <= pend_w_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pend_w_d = pend_w_q;
    drop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = CW'(width);
          state_d = S_HIGH;
        end
      end

      S_HIGH: begin
        // A retrigger reload wins over the exit so the pulse never glitches low
        if ((RETRIG != 0) && req) begin
          cnt_d = CW'(width);
        end else begin
          if ((RETRIG == 0) && tick) drop = 1'b1;
          if (last) begin
            cnt_d   = CNT_GAP;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      S_GAP: begin
        if (req && pend_q) drop = 1'b1;
        if (last) begin
          if (pend_q) begin
            cnt_d   = CW'(pend_w_q);
            pend_d  = 1'b0;
            state_d = S_HIGH;
          end else if (req) begin
            cnt_d   = CW'(width);
            state_d = S_HIGH;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (req && !pend_q) begin
            pend_d   = 1'b1;
            pend_w_d = width;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the current state, so they lag it by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      level   <= (state_q == S_HIGH);
      busy    <= (state_q != S_IDLE);
      overrun <= drop;
    end
  end

endmodule

// File: tb/tb_level_gen.sv
// Self-checking bench for level_gen: two instances (drop / retrigger) driven
// by shared stimulus and compared against a deadline-based reference model.
module tb_level_gen;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick  = 1'b0;
  logic [7:0] width = '0;
  logic [1:0] lvl_o, busy_o, ovr_o;

  level_gen #(.WIDTH_W(8), .GAP(2), .RETRIG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .width(width),
    .level(lvl_o[0]), .busy(busy_o[0]), .overrun(ovr_o[0])
  );

  level_gen #(.WIDTH_W(8), .GAP(3), .RETRIG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .width(width),
    .level(lvl_o[1]), .busy(busy_o[1]), .overrun(ovr_o[1])
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each pulse is a pair of absolute deadlines (edge index)
  int gap_p[2]    = '{2, 3};
  bit retrig_p[2] = '{1'b0, 1'b1};
  int hi_end[2], gap_end[2], pend_w[2];
  bit pend[2];
  bit e_lvl[2], e_busy[2], e_ovr[2];
  int k = 0;

  int n_lvl[2], n_busy[2], n_ovr[2], n_rise[2];
  bit prev_lvl[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      hi_end[m]   = -1;
      gap_end[m]  = -1;
      pend[m]     = 1'b0;
      pend_w[m]   = 0;
      e_lvl[m]    = 1'b0;
      e_busy[m]   = 1'b0;
      e_ovr[m]    = 1'b0;
      prev_lvl[m] = 1'b0;
    end
  endtask

  task automatic start_pulse(input int m, input int w);
    hi_end[m]  = k + w;
    gap_end[m] = k + w + gap_p[m];
  endtask

  task automatic model_edge(input int m, input bit t, input int w);
    bit hi, gp, drop, req;
    req  = t && (w != 0);
    hi   = (k <= hi_end[m]);
    gp   = !hi && (k <= gap_end[m]);
    drop = 1'b0;
    if (hi) begin
      if (retrig_p[m] && req) start_pulse(m, w);
      else if (!retrig_p[m] && t) drop = 1'b1;
    end else if (gp) begin
      if (req && pend[m]) drop = 1'b1;
      if (k == gap_end[m]) begin
        if (pend[m]) begin
          start_pulse(m, pend_w[m]);
          pend[m] = 1'b0;
        end else if (req) begin
          start_pulse(m, w);
        end
      end else if (req && !pend[m]) begin
        pend[m]   = 1'b1;
        pend_w[m] = w;
      end
    end else if (req) begin
      start_pulse(m, w);
    end
    e_lvl[m]  = hi;
    e_busy[m] = hi || gp;
    e_ovr[m]  = drop;
  endtask

  task automatic clr_counts();
    for (int m = 0; m < 2; m++) begin
      n_lvl[m]  = 0;
      n_busy[m] = 0;
      n_ovr[m]  = 0;
      n_rise[m] = 0;
    end
  endtask

  task automatic step(input bit t, input int w);
    tick  = t;
    width = 8'(w);
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_edge(m, t, w);
    k++;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("level%0d", m),   int'(lvl_o[m]),  int'(e_lvl[m]));
      check($sformatf("busy%0d", m),    int'(busy_o[m]), int'(e_busy[m]));
      check($sformatf("overrun%0d", m), int'(ovr_o[m]),  int'(e_ovr[m]));
      n_lvl[m]  += int'(lvl_o[m]);
      n_busy[m] += int'(busy_o[m]);
      n_ovr[m]  += int'(ovr_o[m]);
      if (lvl_o[m] && !prev_lvl[m]) n_rise[m]++;
      prev_lvl[m] = lvl_o[m];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic check_counts(input string tag, input int m, input int lv,
                              input int bz, input int ov, input int rs);
    check($sformatf("%s_lvlcnt%0d", tag, m),  n_lvl[m],  lv);
    check($sformatf("%s_busycnt%0d", tag, m), n_busy[m], bz);
    check($sformatf("%s_ovrcnt%0d", tag, m),  n_ovr[m],  ov);
    check($sformatf("%s_rises%0d", tag, m),   n_rise[m], rs);
  endtask

  task automatic check_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s_level%0d", tag, m),   int'(lvl_o[m]),  0);
      check($sformatf("%s_busy%0d", tag, m),    int'(busy_o[m]), 0);
      check($sformatf("%s_overrun%0d", tag, m), int'(ovr_o[m]),  0);
    end
  endtask

  initial begin
    int t_r, w_r;
    #1;
    // Reset
    tick  = 1'b0;
    width = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_zero("post_reset");

    // Single pulse, width 5
    clr_counts();
    step(1'b1, 5);
    idle(14);
    check_counts("single", 0, 5, 7, 0, 1);
    check_counts("single", 1, 5, 8, 0, 1);

    // Zero width in IDLE
    clr_counts();
    step(1'b1, 0);
    idle(5);
    check_counts("zero_w", 0, 0, 0, 0, 0);
    check_counts("zero_w", 1, 0, 0, 0, 0);

    // Second tick two cycles after the first
    clr_counts();
    step(1'b1, 4);
    step(1'b0, 0);
    step(1'b1, 4);
    idle(14);
    check_counts("overrun", 0, 4, 6, 1, 1);
    check_counts("overrun", 1, 6, 9, 0, 1);

    // Tick on the third high cycle
    clr_counts();
    step(1'b1, 4);
    idle(2);
    step(1'b1, 4);
    idle(14);
    check_counts("retrig", 0, 4, 6, 1, 1);
    check_counts("retrig", 1, 7, 10, 0, 1);

    // Pending request in the gap, then a second tick in the same gap
    clr_counts();
    step(1'b1, 3);
    idle(3);
    step(1'b1, 2);
    step(1'b1, 2);
    idle(14);
    check_counts("pending", 0, 5, 9, 1, 2);
    check_counts("pending", 1, 5, 11, 1, 2);

    // Asynchronous reset between clock edges while level is high
    step(1'b1, 6);
    idle(2);
    check("pre_rst_level0", int'(lvl_o[0]), 1);
    check("pre_rst_level1", int'(lvl_o[1]), 1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_counts();
    step(1'b1, 1);
    idle(8);
    check_counts("after_rst", 0, 1, 3, 0, 1);
    check_counts("after_rst", 1, 1, 4, 0, 1);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 800; i++) begin
      t_r = ($urandom_range(0, 9) < 4) ? 1 : 0;
      case ($urandom_range(0, 7))
        0:       w_r = 0;
        1:       w_r = 1;
        2:       w_r = $urandom_range(8, 20);
        default: w_r = $urandom_range(1, 6);
      endcase
      step(t_r[0], w_r);
    end
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
